// File: rtl/sec_disp_if.sv
// Bundle between the upstream seconds counter, the BCD converter and the
// multiplexed two-digit 7-segment display.
interface sec_disp_if;
    logic [5:0] bin;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;
    logic [6:0] seg;
    logic [1:0] dig;

    modport master (
        output bin,
        input  bcd_tens,
        input  bcd_ones,
        input  busy,
        input  seg,
        input  dig
    );

    modport slave (
        input  bin,
        output bcd_tens,
        output bcd_ones,
        output busy,
        output seg,
        output dig
    );
endinterface

// File: rtl/sec_disp.sv
// Seconds value to two BCD digits via sequential double-dabble, with a
// free-running scan that multiplexes both digits onto one 7-segment bus.
module sec_disp #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    sec_disp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        state_reg;
    logic [5:0]    ref_q;
    logic [13:0]   shift_reg;     // {tens, ones, remaining binary bits}
    logic [2:0]    iter_reg;
    logic [3:0]    tens_reg;
    logic [3:0]    ones_reg;
    logic          busy_reg;
    logic [SW-1:0] scan_reg;
    logic          sel_reg;

    logic [7:0]    adj_next;
    logic [13:0]   shift_next;
    logic [3:0]    digit_next;
    logic [6:0]    seg_next;

    genvar gi;

    // Add-3 correction applied to both BCD nibbles before each shift.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign adj_next[gi*4 +: 4] = (shift_reg[6 + gi*4 +: 4] >= 4'd5)
                                       ? shift_reg[6 + gi*4 +: 4] + 4'd3
                                       : shift_reg[6 + gi*4 +: 4];
        end
    endgenerate

    assign shift_next = {adj_next[6:0], shift_reg[5:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ref_q     <= 6'd0;
            shift_reg <= 14'd0;
            iter_reg  <= 3'd0;
            tens_reg  <= 4'd0;
            ones_reg  <= 4'd0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.bin != ref_q) begin
                        shift_reg <= {8'd0, bus.bin};
                        ref_q     <= bus.bin;
                        iter_reg  <= 3'd0;
                        state_reg <= SHIFT;
                        busy_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    iter_reg  <= iter_reg + 3'd1;
                    if (iter_reg == 3'd5) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    tens_reg  <= shift_reg[13:10];
                    ones_reg  <= shift_reg[9:6];
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Scan runs regardless of conversion activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_reg <= '0;
            sel_reg  <= 1'b0;
        end else if (scan_reg == SCAN_LAST) begin
            scan_reg <= '0;
            sel_reg  <= ~sel_reg;
        end else begin
            scan_reg <= scan_reg + 1'b1;
        end
    end

    assign digit_next = sel_reg ? tens_reg : ones_reg;

    always_comb begin
        seg_next = 7'h00;
        case (digit_next)
            4'd0:    seg_next = 7'h3F;
            4'd1:    seg_next = 7'h06;
            4'd2:    seg_next = 7'h5B;
            4'd3:    seg_next = 7'h4F;
            4'd4:    seg_next = 7'h66;
            4'd5:    seg_next = 7'h6D;
            4'd6:    seg_next = 7'h7D;
            4'd7:    seg_next = 7'h07;
            4'd8:    seg_next = 7'h7F;
            4'd9:    seg_next = 7'h6F;
            default: seg_next = 7'h00;
        endcase
        if (BLANK_LZ && sel_reg && (tens_reg == 4'd0)) begin
            seg_next = 7'h00;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_dig
            assign bus.dig[gi] = (sel_reg == 1'(gi));
        end
    endgenerate

    assign bus.seg      = seg_next;
    assign bus.bcd_tens = tens_reg;
    assign bus.bcd_ones = ones_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_sec_disp.sv
// Two instances (scan 4 / no blanking, scan 1 / blanking) driven with the same
// seconds stream and checked every cycle against an arithmetic reference.
module tb_sec_disp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] bin_drv = 6'd0;

    always #5 clk = ~clk;

    sec_disp_if if0 ();
    sec_disp_if if1 ();

    assign if0.bin = bin_drv;
    assign if1.bin = bin_drv;

    sec_disp #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    sec_disp #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: a conversion is a value plus a countdown of remaining edges;
    // digits come from /10 and %10, the scan phase from the edge count.
    bit m_valid = 1'b0;
    int m_ref = 0, m_val = 0, m_left = 0, m_tens = 0, m_ones = 0, m_n = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_ref   <= 0;
            m_left  <= 0;
            m_tens  <= 0;
            m_ones  <= 0;
            m_n     <= 0;
        end else if (m_valid) begin
            m_n <= m_n + 1;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_tens <= m_val / 10;
                    m_ones <= m_val % 10;
                end
            end else if (int'(bin_drv) != m_ref) begin
                m_ref  <= int'(bin_drv);
                m_val  <= int'(bin_drv);
                m_left <= 7;
            end
        end
    end

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_seg(input int sel, input bit blank, input int t, input int o);
        if (blank && sel == 1 && t == 0) return 0;
        return seg_of(sel == 1 ? t : o);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            int sel0, sel1, busy_exp;
            sel0 = (m_n / 4) % 2;
            sel1 = m_n % 2;
            busy_exp = (m_left > 0) ? 1 : 0;
            check("m_tens0", int'(if0.bcd_tens), m_tens);
            check("m_ones0", int'(if0.bcd_ones), m_ones);
            check("m_busy0", int'(if0.busy), busy_exp);
            check("m_dig0",  int'(if0.dig), sel0 == 1 ? 2 : 1);
            check("m_seg0",  int'(if0.seg), exp_seg(sel0, 1'b0, m_tens, m_ones));
            check("m_tens1", int'(if1.bcd_tens), m_tens);
            check("m_ones1", int'(if1.bcd_ones), m_ones);
            check("m_busy1", int'(if1.busy), busy_exp);
            check("m_dig1",  int'(if1.dig), sel1 == 1 ? 2 : 1);
            check("m_seg1",  int'(if1.seg), exp_seg(sel1, 1'b1, m_tens, m_ones));
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_dig(input int which, input int want);
        int cur;
        for (int i = 0; i < 20; i++) begin
            cur = (which == 0) ? int'(if0.dig) : int'(if1.dig);
            if (cur == want) return;
            tick();
        end
        check("dig_timeout", cur, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        bin_drv = 6'd0;
        repeat (3) tick();
        check("rst_dig",  int'(if0.dig), 'h1);
        check("rst_seg",  int'(if0.seg), 'h3F);
        check("rst_busy", int'(if0.busy), 0);
        check("rst_tens", int'(if0.bcd_tens), 0);
        rst_n = 1'b1;

        // bin=0 after reset: no conversion; scan of 4 alternates from reset
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("scan4_dig", int'(if0.dig), (k >= 4 && k < 8) ? 2 : 1);
            check("zero_idle", int'(if0.busy), 0);
        end

        bin_drv = 6'd37;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("c37_busy", int'(if0.busy), 1);
            check("c37_hold", int'(if0.bcd_tens), 0);
        end
        tick();
        check("c37_tens", int'(if0.bcd_tens), 3);
        check("c37_ones", int'(if0.bcd_ones), 7);
        check("c37_idle", int'(if0.busy), 0);

        bin_drv = 6'd59;
        repeat (8) tick();
        check("c59_tens", int'(if0.bcd_tens), 5);
        check("c59_ones", int'(if0.bcd_ones), 9);
        wait_dig(0, 1);
        check("c59_seg_ones", int'(if0.seg), 'h6F);
        wait_dig(0, 2);
        check("c59_seg_tens", int'(if0.seg), 'h6D);

        bin_drv = 6'd0;
        repeat (8) tick();
        check("c0_tens", int'(if0.bcd_tens), 0);
        check("c0_ones", int'(if0.bcd_ones), 0);
        wait_dig(0, 1);
        check("c0_seg_ones", int'(if0.seg), 'h3F);
        wait_dig(0, 2);
        check("c0_seg_tens", int'(if0.seg), 'h3F);

        // bin moves to 45 on edge 3 of the 12 conversion
        bin_drv = 6'd12;
        tick();
        tick();
        bin_drv = 6'd45;
        repeat (6) tick();
        check("c12_tens", int'(if0.bcd_tens), 1);
        check("c12_ones", int'(if0.bcd_ones), 2);
        check("c12_idle", int'(if0.busy), 0);
        tick();
        check("c45_launch", int'(if0.busy), 1);
        repeat (7) tick();
        check("c45_tens", int'(if0.bcd_tens), 4);
        check("c45_ones", int'(if0.bcd_ones), 5);

        bin_drv = 6'd7;
        repeat (8) tick();
        wait_dig(1, 2);
        check("b7_seg_tens", int'(if1.seg), 0);
        wait_dig(1, 1);
        check("b7_seg_ones", int'(if1.seg), 'h07);

        bin_drv = 6'd63;
        repeat (8) tick();
        check("c63_tens", int'(if1.bcd_tens), 6);
        check("c63_ones", int'(if1.bcd_ones), 3);
        wait_dig(1, 2);
        check("c63_seg_tens", int'(if1.seg), 'h7D);
        wait_dig(1, 1);
        check("c63_seg_ones", int'(if1.seg), 'h4F);

        // reset on edge 4 of a conversion of 50
        bin_drv = 6'd50;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("abort_tens", int'(if0.bcd_tens), 0);
        check("abort_ones", int'(if0.bcd_ones), 0);
        check("abort_busy", int'(if0.busy), 0);
        rst_n = 1'b1;
        repeat (7) tick();
        check("c50_busy", int'(if0.busy), 1);
        check("c50_hold", int'(if0.bcd_tens), 0);
        tick();
        check("c50_tens", int'(if0.bcd_tens), 5);
        check("c50_ones", int'(if0.bcd_ones), 0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            bin_drv = 6'($urandom_range(0, 63));
            repeat ($urandom_range(1, 12)) tick();
        end
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
